// File: rtl/add4_accum.sv
// Accumulates N_OPS 5-bit operands ({carry,sum}) from a 4-bit adder stage into an 8-bit register.
// Optional macro ADD4_ACCUM_SATURATE_EN clamps overflowing adds to 8'hFF instead of wrapping.
module add4_accum #(
  parameter int N_OPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic       in_carry,
  output logic       in_ready,
  output logic [7:0] acc_out,
  output logic [3:0] count,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] LAST   = 4'(N_OPS - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       rdy_q, busy_q, done_q;
  logic [8:0] sum9;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sum9    = {1'b0, acc_q} + {4'b0000, in_carry, in_data};
    case (state_q)
      S_IDLE: begin
        // in_valid is deliberately ignored here, even alongside start
        if (start) begin
          state_d = S_ACC;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ACC: begin
        if (in_valid && rdy_q) begin
          cnt_d = cnt_q + 4'd1;
          if (sum9[8]) begin
            ovf_d = 1'b1;
`ifdef ADD4_ACCUM_SATURATE_EN
            acc_d = 8'hFF;
`else
            acc_d = sum9[7:0];
`endif
          end else begin
            acc_d = sum9[7:0];
          end
          if (cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= (state_d == S_ACC);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign in_ready = rdy_q;
  assign acc_out  = acc_q;
  assign count    = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_add4_accum.sv
// Bench for add4_accum: an N_OPS=8 and an N_OPS=10 instance share operand inputs, each has its own start.
module tb_add4_accum;

`ifdef ADD4_ACCUM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_v [2];
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       in_carry = 1'b0;
  logic       rdy_o  [2];
  logic [7:0] acc_o  [2];
  logic [3:0] cnt_o  [2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       ovf_o  [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int nops [2] = '{8, 10};
  int m_st [2] = '{0, 0};
  int m_acc[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  int m_ovf[2] = '{0, 0};

  always #5 clk = ~clk;

  add4_accum #(.N_OPS(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_data(in_data),
    .in_carry(in_carry), .in_ready(rdy_o[0]), .acc_out(acc_o[0]), .count(cnt_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .ovf(ovf_o[0])
  );

  add4_accum #(.N_OPS(10)) dut10 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_data(in_data),
    .in_carry(in_carry), .in_ready(rdy_o[1]), .acc_out(acc_o[1]), .count(cnt_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .ovf(ovf_o[1])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Run-level model: phase 0 idle, 1 accumulating, 2 the single done cycle.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_st[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      end else if (m_st[k] == 0) begin
        if (start_v[k]) begin
          m_st[k] = 1; m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
      end else if (m_st[k] == 1) begin
        if (in_valid) begin
          int s;
          s = m_acc[k] + (in_carry ? 16 : 0) + int'(in_data);
          if (s > 255) begin
            m_ovf[k] = 1;
            m_acc[k] = SAT ? 255 : s % 256;
          end else begin
            m_acc[k] = s;
          end
          m_cnt[k]++;
          if (m_cnt[k] == nops[k]) m_st[k] = 2;
        end
      end else begin
        m_st[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("acc_out[%0d]", k), int'(acc_o[k]), m_acc[k]);
        chk($sformatf("count[%0d]", k), int'(cnt_o[k]), m_cnt[k]);
        chk($sformatf("ovf[%0d]", k), int'(ovf_o[k]), m_ovf[k]);
        chk($sformatf("in_ready[%0d]", k), int'(rdy_o[k]), int'(m_st[k] == 1));
        chk($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(m_st[k] != 0));
        chk($sformatf("done[%0d]", k), int'(done_o[k]), int'(m_st[k] == 2));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    #1 rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset acc", int'(acc_o[0]), 0);
    chk("reset busy", int'(busy_o[0]), 0);

    // in_valid in IDLE without start
    in_valid = 1'b1; in_data = 4'd5;
    cyc(2);
    chk("idle in_ready", int'(rdy_o[0]), 0);
    chk("idle acc", int'(acc_o[0]), 0);
    in_valid = 1'b0;

    // 8 back-to-back transfers of 15
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    in_valid = 1'b1; in_data = 4'hF; in_carry = 1'b0;
    cyc(8);
    in_valid = 1'b0;
    chk("run1 acc", int'(acc_o[0]), 120);
    chk("run1 done", int'(done_o[0]), 1);
    chk("run1 ovf", int'(ovf_o[0]), 0);
    cyc(1);
    chk("run1 done drop", int'(done_o[0]), 0);
    chk("run1 busy", int'(busy_o[0]), 0);
    chk("run1 hold", int'(acc_o[0]), 120);

    // start with in_valid together: no transfer; then alternating gaps with operand 3
    start_v[0] = 1'b1; in_valid = 1'b1; in_data = 4'd3;
    cyc(1);
    start_v[0] = 1'b0; in_valid = 1'b0;
    chk("start+valid count", int'(cnt_o[0]), 0);
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      cyc(1);
      in_valid = 1'b0;
      chk("gap count", int'(cnt_o[0]), i);
      if (i == 8) chk("run2 done", int'(done_o[0]), 1);
      cyc(1);
      chk("gap hold", int'(cnt_o[0]), i);
    end
    chk("run2 acc", int'(acc_o[0]), 24);

    // N_OPS=10, ten operands of 31
    start_v[1] = 1'b1;
    cyc(1);
    start_v[1] = 1'b0;
    in_valid = 1'b1; in_data = 4'hF; in_carry = 1'b1;
    cyc(10);
    in_valid = 1'b0; in_carry = 1'b0;
    chk("run3 acc", int'(acc_o[1]), SAT ? 255 : 54);
    chk("run3 ovf", int'(ovf_o[1]), 1);
    chk("run3 done", int'(done_o[1]), 1);
    cyc(2);

    // start pulsed mid-run is ignored
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    in_valid = 1'b1; in_data = 4'd2;
    cyc(3);
    in_valid = 1'b0; start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    chk("mid start count", int'(cnt_o[0]), 3);
    in_valid = 1'b1;
    cyc(5);
    in_valid = 1'b0;
    chk("run4 acc", int'(acc_o[0]), 16);
    chk("run4 count", int'(cnt_o[0]), 8);
    cyc(2);

    // asynchronous reset mid-run
    start_v[0] = 1'b1;
    cyc(1);
    start_v[0] = 1'b0;
    in_valid = 1'b1; in_data = 4'd1;
    cyc(4);
    in_valid = 1'b0;
    chk("pre-rst acc", int'(acc_o[0]), 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async acc", int'(acc_o[0]), 0);
    chk("async count", int'(cnt_o[0]), 0);
    chk("async busy", int'(busy_o[0]), 0);
    chk("async in_ready", int'(rdy_o[0]), 0);
    chk("async ovf10", int'(ovf_o[1]), 0);
    cyc(1);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 4'd7;
    cyc(5);
    in_valid = 1'b0;
    chk("post-rst count", int'(cnt_o[0]), 0);
    chk("post-rst acc", int'(acc_o[0]), 0);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
